// File: rtl/timer_regif.sv
// rtl/timer_regif.sv - APB-style register interface for an 8-bit up/down timer
module timer_regif (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] start_counter,
  output logic       load,
  output logic       up_down,
  output logic       enable,
  output logic [1:0] cks,
  output logic       clr_overflow,
  output logic       clr_underflow,
  input  logic       overflow,
  input  logic       underflow,
  output logic       irq
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // state holds last cycle's bus phase; phase is the phase of the current cycle
  logic [1:0] state;
  logic [1:0] phase;
  logic [7:0] tdr;
  logic       ud_q;
  logic       en_q;
  logic [1:0] cks_q;
  logic [1:0] tier;
  logic       load_q;
  logic       clr_ov_q;
  logic       clr_un_q;
  logic       irq_q;
  logic       in_access;
  logic       addr_ok;
  logic       commit;
  logic [7:0] rd_mux;

  always_comb begin
    phase = IDLE;
    case (state)
      IDLE:    if (psel && !penable) phase = SETUP;
      SETUP:   if (psel && penable) phase = ACCESS;
               else if (psel) phase = SETUP;
      ACCESS:  if (psel && !penable) phase = SETUP;
      default: phase = IDLE;
    endcase
  end

  assign in_access = !rst && (phase == ACCESS);
  assign addr_ok   = (paddr <= 8'h03);
  assign commit    = in_access && pwrite && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tdr      <= 8'h00;
      ud_q     <= 1'b0;
      en_q     <= 1'b0;
      cks_q    <= 2'b00;
      tier     <= 2'b00;
      load_q   <= 1'b0;
      clr_ov_q <= 1'b0;
      clr_un_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state    <= phase;
      load_q   <= commit && (paddr[1:0] == 2'd1) && pwdata[7];
      clr_ov_q <= commit && (paddr[1:0] == 2'd2) && pwdata[0];
      clr_un_q <= commit && (paddr[1:0] == 2'd2) && pwdata[1];
      irq_q    <= (overflow && tier[0]) || (underflow && tier[1]);
      if (commit) begin
        case (paddr[1:0])
          2'd0: tdr <= pwdata;
          2'd1: begin
            ud_q  <= pwdata[5];
            en_q  <= pwdata[4];
            cks_q <= pwdata[1:0];
          end
          2'd3: tier <= pwdata[1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (paddr[1:0])
      2'd0: rd_mux = tdr;
      2'd1: rd_mux = {2'b00, ud_q, en_q, 2'b00, cks_q};
      2'd2: rd_mux = {6'b000000, underflow, overflow};
      2'd3: rd_mux = {6'b000000, tier};
      default: rd_mux = 8'h00;
    endcase
  end

  // Pulses already scheduled are masked while reset is held
  assign load          = load_q && !rst;
  assign clr_overflow  = clr_ov_q && !rst;
  assign clr_underflow = clr_un_q && !rst;
  assign start_counter = tdr;
  assign up_down       = ud_q;
  assign enable        = en_q;
  assign cks           = cks_q;
  assign irq           = irq_q;
  assign pready        = in_access;
  assign pslverr       = (in_access && !addr_ok) ||
                         (!rst && psel && penable && (phase != ACCESS));
  assign prdata        = (in_access && !pwrite && addr_ok) ? rd_mux : 8'h00;

endmodule

// File: tb/tb_timer_regif.sv
// tb/tb_timer_regif.sv - self-checking bench for timer_regif with a transfer-level model
module tb_timer_regif;

  logic       clk = 1'b0;
  logic       rst, psel, penable, pwrite, overflow, underflow;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata, start_counter;
  logic       pready, pslverr, load, up_down, enable, clr_overflow, clr_underflow, irq;
  logic [1:0] cks;

  timer_regif dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .start_counter(start_counter), .load(load), .up_down(up_down), .enable(enable),
    .cks(cks), .clr_overflow(clr_overflow), .clr_underflow(clr_underflow),
    .overflow(overflow), .underflow(underflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: register contents and outputs expected in the current cycle
  logic [7:0] m_tdr, m_tcr;
  logic [1:0] m_tier;
  logic       m_load, m_cov, m_cun, m_irq;
  logic       f_ov = 1'b0, f_un = 1'b0;
  logic [7:0] last_rd;
  logic       last_err, last_load;

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return {6'b0, f_un, f_ov};
      8'h03:   return {6'b0, m_tier};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_tdr = 8'h00; m_tcr = 8'h00; m_tier = 2'b00;
    m_load = 1'b0; m_cov = 1'b0; m_cun = 1'b0; m_irq = 1'b0;
  endtask

  // role: 0 = idle/setup cycle, 1 = access after setup, 2 = penable without setup
  task automatic tick(input logic r, s, e, w, input logic [7:0] a, d, input int role);
    logic       xp, xe;
    logic [7:0] xr;
    @(posedge clk); #1;
    rst = r; psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    overflow = f_ov; underflow = f_un;
    @(negedge clk);
    xp = !r && role == 1;
    xe = !r && ((role == 1 && a > 8'h03) || role == 2);
    xr = (xp && !w) ? model_read(a) : 8'h00;
    chk("pready", pready, xp);
    chk("pslverr", pslverr, xe);
    chk("prdata", prdata, xr);
    chk("start_counter", start_counter, m_tdr);
    chk("ud_en_cks", {up_down, enable, cks}, {m_tcr[5], m_tcr[4], m_tcr[1:0]});
    chk("load", load, r ? 1'b0 : m_load);
    chk("clr_pair", {clr_underflow, clr_overflow}, r ? 2'b00 : {m_cun, m_cov});
    chk("irq", irq, m_irq);
    last_rd = prdata; last_err = pslverr; last_load = load;
    if (r) model_reset();
    else begin
      m_irq  = (f_ov && m_tier[0]) || (f_un && m_tier[1]);
      m_load = 1'b0; m_cov = 1'b0; m_cun = 1'b0;
      if (role == 1 && w) begin
        case (a)
          8'h00: m_tdr = d;
          8'h01: begin m_tcr = d & 8'h33; m_load = d[7]; end
          8'h02: begin m_cov = d[0]; m_cun = d[1]; end
          8'h03: m_tier = d[1:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0);
  endtask

  task automatic xfer(input logic [7:0] a, input logic w, input logic [7:0] d);
    tick(1'b0, 1'b1, 1'b0, w, a, d, 0);
    tick(1'b0, 1'b1, 1'b1, w, a, d, 1);
  endtask

  initial begin
    logic [5:0]  pat;
    logic [7:0]  a, d;
    logic        w;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; overflow = 1'b0; underflow = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    idle();

    tbl[0]  = '{8'h00, 1'b1, 8'h0A, 8'h00, 1'b0};
    tbl[1]  = '{8'h01, 1'b1, 8'h80, 8'h00, 1'b0};
    tbl[2]  = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 8'h0A, 1'b0};
    tbl[4]  = '{8'h01, 1'b1, 8'hB1, 8'h00, 1'b0};
    tbl[5]  = '{8'h01, 1'b0, 8'h00, 8'h31, 1'b0};
    tbl[6]  = '{8'h07, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{8'h05, 1'b1, 8'hFF, 8'h00, 1'b1};
    tbl[8]  = '{8'h00, 1'b0, 8'h00, 8'h0A, 1'b0};
    tbl[9]  = '{8'h01, 1'b0, 8'h00, 8'h31, 1'b0};
    tbl[10] = '{8'h01, 1'b1, 8'h4E, 8'h00, 1'b0};
    tbl[11] = '{8'h01, 1'b0, 8'h00, 8'h02, 1'b0};
    tbl[12] = '{8'h03, 1'b1, 8'hFF, 8'h00, 1'b0};
    tbl[13] = '{8'h03, 1'b0, 8'h00, 8'h03, 1'b0};
    tbl[14] = '{8'h03, 1'b1, 8'h02, 8'h00, 1'b0};
    tbl[15] = '{8'h02, 1'b0, 8'h00, 8'h03, 1'b0};
    tbl[16] = '{8'h02, 1'b1, 8'h02, 8'h00, 1'b0};

    f_ov = 1'b1; f_un = 1'b1;
    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i].addr, tbl[i].wr, tbl[i].data);
      chk("tbl_prdata", last_rd, tbl[i].exp_rd);
      chk("tbl_pslverr", last_err, tbl[i].exp_err);
      idle();
    end
    chk("irq_udf_only", irq, 1'b1);
    f_ov = 1'b0; f_un = 1'b0;
    idle(); idle();

    // back-to-back LD writes: pulses two cycles apart, one cycle wide each
    pat = 6'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h80, 0); pat = {pat[4:0], last_load};
      tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h80, 1); pat = {pat[4:0], last_load};
    end
    idle(); pat = {pat[4:0], last_load};
    idle(); pat = {pat[4:0], last_load};
    chk("b2b_load_pattern", {2'b00, pat}, 8'b00001010);

    // reset during the access of a TCR=0x90 write
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h90, 0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h90, 1);
    idle();
    chk("rst_access_load", load, 1'b0);
    chk("rst_access_enable", enable, 1'b0);
    xfer(8'h01, 1'b0, 8'h00);
    chk("rst_access_tcr", last_rd, 8'h00);
    idle();

    // reset in setup, then an access with no new setup must not commit
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 2);
    idle();
    xfer(8'h00, 1'b0, 8'h00);
    chk("rst_setup_tdr", last_rd, 8'h00);
    idle();

    // penable without setup from idle
    xfer(8'h00, 1'b1, 8'h12); idle();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h77, 2);
    chk("noset_pslverr", last_err, 1'b1);
    idle();
    xfer(8'h00, 1'b0, 8'h00);
    chk("noset_tdr", last_rd, 8'h12);
    idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        f_ov = 1'($urandom_range(0, 1));
        f_un = 1'($urandom_range(0, 1));
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) tick(1'b0, 1'b1, 1'b1, w, a, d, 2);
      else xfer(a, w, d);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
